// File: rtl/nfc_symbol_decoder.sv
// nfc_symbol_decoder
// Recovers symbols from the demodulated NFC envelope by measuring the
// length of each constant-level run.  After LOCK_RUNS consecutive runs of
// legal length the decoder locks and emits one symbol per completed good run.
// A bad run or a timeout while locked counts an error and drops back to hunting.
//
// Build option: define NFC_DEGLITCH_EN to insert a GLITCH_CYCLES-deep
// persistence filter between the synchronizer and the edge detector.
// Without it the synchronized envelope feeds the edge detector directly.

module nfc_symbol_decoder #(
   parameter int unsigned RUN_W         = 16,
   parameter int unsigned MIN_RUN       = 40,
   parameter int unsigned MAX_RUN       = 60,
   parameter int unsigned LOCK_RUNS     = 4,
   parameter int unsigned GLITCH_CYCLES = 3,
   parameter int unsigned ERR_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             recv,
   output logic             sym_valid,
   output logic             sym_data,
   output logic [RUN_W-1:0] sym_len,
   output logic             lock,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [RUN_W-1:0] MIN_L   = RUN_W'(MIN_RUN);
   localparam logic [RUN_W-1:0] MAX_L   = RUN_W'(MAX_RUN);
   localparam logic [RUN_W-1:0] SAT_L   = RUN_W'(MAX_RUN + 1);
   localparam int unsigned      GOOD_W  = $clog2(LOCK_RUNS + 1);
   localparam logic [GOOD_W-1:0] LOCK_M1 = GOOD_W'(LOCK_RUNS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HUNT,
      ST_LOCKED
   } state_e;

   // ------------------------------------------------------------------
   // Synchronizer
   // ------------------------------------------------------------------
   logic sync1_q;
   logic sync2_q;

   // Two-flop synchronizer for the asynchronous envelope.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= recv;
         sync2_q <= sync1_q;
      end
   end

   // ------------------------------------------------------------------
   // Optional deglitch filter
   // ------------------------------------------------------------------
   logic filt;

`ifdef NFC_DEGLITCH_EN
   localparam int unsigned       GC_W    = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
   localparam logic [GC_W-1:0]   GC_LAST = GC_W'(GLITCH_CYCLES - 1);

   logic            filt_q;
   logic            filt_d;
   logic [GC_W-1:0] gcnt_q;
   logic [GC_W-1:0] gcnt_d;

   // Count consecutive disagreeing cycles; flip on the GLITCH_CYCLES-th one.
   always_comb begin
      filt_d = filt_q;
      gcnt_d = '0;
      if (sync2_q != filt_q) begin
         if (gcnt_q == GC_LAST) begin
            filt_d = sync2_q;
         end else begin
            gcnt_d = gcnt_q + 1'b1;
         end
      end
   end

   // Filter state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= 1'b0;
         gcnt_q <= '0;
      end else begin
         filt_q <= filt_d;
         gcnt_q <= gcnt_d;
      end
   end

   assign filt = filt_q;
`else
   // Filter depth has no role without the deglitcher.
   logic unused_glitch_cfg;
   assign unused_glitch_cfg = ^GLITCH_CYCLES;

   assign filt = sync2_q;
`endif

   // ------------------------------------------------------------------
   // Edge detection and run-length measurement
   // ------------------------------------------------------------------
   logic             filt_prev_q;
   logic [RUN_W-1:0] run_q;
   logic [RUN_W-1:0] run_d;
   logic             edge_det;
   logic             len_ok;
   logic             timeout;
   logic             good_run;
   logic             bad_run;

   assign edge_det = (filt != filt_prev_q);
   assign len_ok   = (run_q >= MIN_L) && (run_q <= MAX_L);
   // Fires only on the step into saturation, so a stuck level counts once.
   assign timeout  = !edge_det && (run_q == MAX_L);
   assign good_run = edge_det && len_ok;
   assign bad_run  = (edge_det && !len_ok) || timeout;

   // Run counter: restart on an edge, otherwise count up to MAX_RUN+1 and hold.
   always_comb begin
      run_d = run_q;
      if (edge_det) begin
         run_d = RUN_W'(1);
      end else if (run_q != SAT_L) begin
         run_d = run_q + 1'b1;
      end
   end

   // Previous filtered level and run counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_prev_q <= 1'b0;
         run_q       <= '0;
      end else begin
         filt_prev_q <= filt;
         run_q       <= run_d;
      end
   end

   // ------------------------------------------------------------------
   // Lock FSM, symbol output and error counter
   // ------------------------------------------------------------------
   state_e             state_q;
   state_e             state_d;
   logic [GOOD_W-1:0]  good_q;
   logic [GOOD_W-1:0]  good_d;
   logic [ERR_W-1:0]   err_q;
   logic [ERR_W-1:0]   err_d;
   logic               sym_valid_q;
   logic               sym_valid_d;
   logic               sym_data_q;
   logic               sym_data_d;
   logic [RUN_W-1:0]   sym_len_q;
   logic [RUN_W-1:0]   sym_len_d;

   // Next-state, good-run tally, symbol capture and error counting.
   always_comb begin
      state_d     = state_q;
      good_d      = good_q;
      err_d       = err_q;
      sym_valid_d = 1'b0;
      sym_data_d  = sym_data_q;
      sym_len_d   = sym_len_q;
      unique case (state_q)
         ST_IDLE: begin
            // The run ending here started at an unknown time; discard it.
            if (edge_det) begin
               state_d = ST_HUNT;
               good_d  = '0;
            end
         end
         ST_HUNT: begin
            if (bad_run) begin
               good_d = '0;
            end else if (good_run) begin
               // The run that completes the lock is not emitted as a symbol.
               if (good_q == LOCK_M1) begin
                  state_d = ST_LOCKED;
                  good_d  = '0;
               end else begin
                  good_d = good_q + 1'b1;
               end
            end
         end
         ST_LOCKED: begin
            if (bad_run) begin
               if (err_q != '1) begin
                  err_d = err_q + 1'b1;
               end
               state_d = ST_HUNT;
               good_d  = '0;
            end else if (good_run) begin
               // filt already shows the new level; the finished run had the old one.
               sym_valid_d = 1'b1;
               sym_data_d  = filt_prev_q;
               sym_len_d   = run_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            good_d  = '0;
         end
      endcase
   end

   // FSM and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         good_q      <= '0;
         err_q       <= '0;
         sym_valid_q <= 1'b0;
         sym_data_q  <= 1'b0;
         sym_len_q   <= '0;
      end else begin
         state_q     <= state_d;
         good_q      <= good_d;
         err_q       <= err_d;
         sym_valid_q <= sym_valid_d;
         sym_data_q  <= sym_data_d;
         sym_len_q   <= sym_len_d;
      end
   end

   assign sym_valid = sym_valid_q;
   assign sym_data  = sym_data_q;
   assign sym_len   = sym_len_q;
   assign lock      = (state_q == ST_LOCKED);
   assign err_count = err_q;

endmodule

// File: tb/tb_nfc_symbol_decoder.sv
// Testbench for nfc_symbol_decoder: table of envelope runs with expected
// symbol/lock/error state, followed by hand-written timeout, glitch, reset
// and error-saturation sequences.
`timescale 1ns/1ps

module tb_nfc_symbol_decoder;

   localparam int RUN_W = 16;
   localparam int ERR_W = 16;
`ifdef NFC_DEGLITCH_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             recv;
   logic             sym_valid;
   logic             sym_data;
   logic [RUN_W-1:0] sym_len;
   logic             lock;
   logic [ERR_W-1:0] err_count;
   logic             sym_valid2;
   logic             sym_data2;
   logic [RUN_W-1:0] sym_len2;
   logic             lock2;
   logic [1:0]       err_count2;

   always #5 clk = ~clk;

   nfc_symbol_decoder #(
      .RUN_W(RUN_W), .MIN_RUN(40), .MAX_RUN(60), .LOCK_RUNS(4),
      .GLITCH_CYCLES(3), .ERR_W(ERR_W)
   ) u_dut (
      .clk(clk), .rst(rst), .recv(recv), .sym_valid(sym_valid),
      .sym_data(sym_data), .sym_len(sym_len), .lock(lock), .err_count(err_count)
   );

   nfc_symbol_decoder #(
      .RUN_W(RUN_W), .MIN_RUN(40), .MAX_RUN(60), .LOCK_RUNS(4),
      .GLITCH_CYCLES(3), .ERR_W(2)
   ) u_dut2 (
      .clk(clk), .rst(rst), .recv(recv), .sym_valid(sym_valid2),
      .sym_data(sym_data2), .sym_len(sym_len2), .lock(lock2), .err_count(err_count2)
   );

   int checks    = 0;
   int passed    = 0;
   int sym_total = 0;
   int last_data = 0;
   int last_len  = 0;
   int exp_err   = 0;

   // Symbol monitor, sampled 1 ns after the rising edge.
   always @(posedge clk) begin
      #1;
      if (sym_valid) begin
         sym_total = sym_total + 1;
         last_data = int'(sym_data);
         last_len  = int'(sym_len);
      end
   end

   typedef struct {
      bit lvl;
      int len;
      int e_sym;
      int e_data;
      int e_len;
      int e_lock;
      int e_err;
   } vec_t;

   vec_t vecs [21];

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act == exp) passed = passed + 1;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic run_seg(input bit l, input int n);
      recv = l;
      repeat (n) @(negedge clk);
   endtask

   // Six alternating 50-cycle runs: at least five good runs, always enough to lock.
   task automatic relock(input string tag);
      bit lvl;
      lvl = ~recv;
      for (int i = 0; i < 6; i++) run_seg(lvl ^ i[0], 50);
      chk({tag, " lock"}, int'(lock), 1);
   endtask

   initial begin
      int base;
      int e0;

      //          lvl  len  sym data len lock err
      vecs[0]  = '{1'b0, 50, 0, 0,  0, 0, 0};
      vecs[1]  = '{1'b1, 50, 0, 0,  0, 0, 0};
      vecs[2]  = '{1'b0, 50, 0, 0,  0, 0, 0};
      vecs[3]  = '{1'b1, 50, 0, 0,  0, 0, 0};
      vecs[4]  = '{1'b0, 50, 0, 0,  0, 0, 0};
      vecs[5]  = '{1'b1, 50, 0, 0,  0, 1, 0};
      vecs[6]  = '{1'b0, 50, 1, 1, 50, 1, 0};
      vecs[7]  = '{1'b1, 30, 1, 0, 50, 1, 0};
      vecs[8]  = '{1'b0, 50, 0, 0,  0, 0, 1};
      vecs[9]  = '{1'b1, 50, 0, 0,  0, 0, 1};
      vecs[10] = '{1'b0, 50, 0, 0,  0, 0, 1};
      vecs[11] = '{1'b1, 50, 0, 0,  0, 0, 1};
      vecs[12] = '{1'b0, 50, 0, 0,  0, 1, 1};
      vecs[13] = '{1'b1, 50, 1, 0, 50, 1, 1};
      vecs[14] = '{1'b0, 45, 1, 1, 50, 1, 1};
      vecs[15] = '{1'b1, 60, 1, 0, 45, 1, 1};
      vecs[16] = '{1'b0, 40, 1, 1, 60, 1, 1};
      vecs[17] = '{1'b1, 61, 1, 0, 40, 1, 1};
      vecs[18] = '{1'b0, 50, 0, 0,  0, 0, 2};
      vecs[19] = '{1'b1, 39, 0, 0,  0, 0, 2};
      vecs[20] = '{1'b0, 50, 0, 0,  0, 0, 2};

      // Reset state
      rst  = 1'b1;
      recv = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset sym_valid", int'(sym_valid), 0);
      chk("reset sym_data", int'(sym_data), 0);
      chk("reset sym_len", int'(sym_len), 0);
      chk("reset lock", int'(lock), 0);
      chk("reset err_count", int'(err_count), 0);
      rst = 1'b0;

      // Table: each entry checks the run that ended at its own start.
      for (int i = 0; i < 21; i++) begin
         base = sym_total;
         run_seg(vecs[i].lvl, vecs[i].len);
         chk($sformatf("v%0d sym_count", i), sym_total - base, vecs[i].e_sym);
         if (vecs[i].e_sym != 0) begin
            chk($sformatf("v%0d sym_data", i), last_data, vecs[i].e_data);
            chk($sformatf("v%0d sym_len", i), last_len, vecs[i].e_len);
         end
         chk($sformatf("v%0d lock", i), int'(lock), vecs[i].e_lock);
         chk($sformatf("v%0d err_count", i), int'(err_count), vecs[i].e_err);
      end
      exp_err = 2;
      chk("hold sym_data", int'(sym_data), 0);
      chk("hold sym_len", int'(sym_len), 40);

      // Stuck-high envelope while locked: one timeout error, then nothing more.
      relock("A");
      e0   = exp_err;
      recv = 1'b1;
      repeat (62 + LAT) @(negedge clk);
      chk("A lock before timeout", int'(lock), 1);
      @(negedge clk);
      chk("A lock at timeout", int'(lock), 0);
      chk("A err at timeout", int'(err_count), e0 + 1);
      repeat (200 - 63 - LAT) @(negedge clk);
      chk("A err during hold", int'(err_count), e0 + 1);
      run_seg(1'b0, 50);
      chk("A err after edge", int'(err_count), e0 + 1);
      chk("A lock after edge", int'(lock), 0);
      exp_err = e0 + 1;

      // Two-cycle low glitch inside a 50-cycle high run.
      relock("B");
      recv = 1'b1;
      repeat (20) @(negedge clk);
      base = sym_total;
      recv = 1'b0;
      repeat (2) @(negedge clk);
      recv = 1'b1;
      repeat (28) @(negedge clk);
      recv = 1'b0;
      repeat (50) @(negedge clk);
`ifdef NFC_DEGLITCH_EN
      chk("B sym_count", sym_total - base, 1);
      chk("B sym_data", last_data, 1);
      chk("B sym_len", last_len, 50);
      chk("B lock", int'(lock), 1);
`else
      exp_err = exp_err + 1;
      chk("B sym_count", sym_total - base, 0);
      chk("B lock", int'(lock), 0);
`endif
      chk("B err_count", int'(err_count), exp_err);

      // Asynchronous reset in the middle of a locked run.
      relock("C");
      chk("C err before reset", int'(err_count), exp_err);
      chk("C sym_len before reset", int'(sym_len), 50);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("C async lock", int'(lock), 0);
      chk("C async err_count", int'(err_count), 0);
      chk("C async sym_valid", int'(sym_valid), 0);
      chk("C async sym_data", int'(sym_data), 0);
      chk("C async sym_len", int'(sym_len), 0);
      recv = 1'b0;
      repeat (3) @(negedge clk);
      rst     = 1'b0;
      exp_err = 0;
      run_seg(1'b1, 50);
      run_seg(1'b0, 50);
      run_seg(1'b1, 50);
      run_seg(1'b0, 50);
      chk("C lock after 3 good", int'(lock), 0);
      run_seg(1'b1, 50);
      chk("C lock after 4 good", int'(lock), 1);
      chk("C err after relock", int'(err_count), 0);

      // Error counter saturation on the 2-bit instance.
      for (int i = 1; i <= 5; i++) begin
         relock($sformatf("D%0d", i));
         run_seg(~recv, 30);
         run_seg(~recv, 50);
         exp_err = exp_err + 1;
         chk($sformatf("D%0d err_count", i), int'(err_count), exp_err);
         chk($sformatf("D%0d err_count2", i), int'(err_count2), (exp_err > 3) ? 3 : exp_err);
         chk($sformatf("D%0d lock", i), int'(lock), 0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
